// File: rtl/cpu_pkg.sv
// Shared decode definitions: opcodes, instruction field positions,
// and the registered bundle handed from decode to execute.
package cpu_pkg;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_BEQZ = 4'hC;
    localparam logic [3:0] OP_BNEZ = 4'hD;
    localparam logic [3:0] OP_J    = 4'hE;
    localparam logic [3:0] OP_JR   = 4'hF;

    localparam int OP_HI   = 15;
    localparam int OP_LO   = 12;
    localparam int RD_HI   = 11;
    localparam int RD_LO   = 9;
    localparam int RS_HI   = 8;
    localparam int RS_LO   = 6;
    localparam int RT_HI   = 5;
    localparam int RT_LO   = 3;
    localparam int FUNC_HI = 2;
    localparam int FUNC_LO = 0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [2:0]  func;
        logic [2:0]  rd;
        logic        reg_write;
        logic [15:0] rs_val;
        logic [15:0] rt_val;
        logic [15:0] imm;
        logic [15:0] next_pc;
    } ex_bundle_t;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    function automatic logic [15:0] sext12(input logic [11:0] v);
        return {{4{v[11]}}, v};
    endfunction

endpackage

// File: rtl/decode_hazard.sv
// Load-use detector: the load sitting in execute writes a register
// that the instruction now in decode wants to read.
module decode_hazard
    import cpu_pkg::*;
(
    input  logic       i_en,
    input  logic       i_ex_valid,
    input  logic [3:0] i_ex_op,
    input  logic [2:0] i_ex_rd,
    input  logic [2:0] i_rs_addr,
    input  logic [2:0] i_rt_addr,
    input  logic       i_uses_rs,
    input  logic       i_uses_rt,
    output logic       o_hazard
);

    logic w_ld_pending;
    logic w_rs_hit;
    logic w_rt_hit;

    assign w_ld_pending = i_en & i_ex_valid
                        & (i_ex_op == OP_LD)
                        & (i_ex_rd != 3'd0);

    assign w_rs_hit = i_uses_rs & (i_rs_addr == i_ex_rd);
    assign w_rt_hit = i_uses_rt & (i_rt_addr == i_ex_rd);

    assign o_hazard = w_ld_pending & (w_rs_hit | w_rt_hit);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: field decode, load-use stall, branch/jump redirect
// and post-redirect squashing of wrong-path fetches.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int FLUSH_SLOTS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] NextPCIn,
    input  logic [15:0] InstructIn,
    input  logic        DownStall,
    output logic [2:0]  RsAddr,
    output logic [2:0]  RtAddr,
    input  logic [15:0] RsData,
    input  logic [15:0] RtData,
    output logic        Stall,
    output logic [15:0] TruePC,
    output logic        NotBranchOrJump,
    output logic        ExValid,
    output logic [3:0]  ExOp,
    output logic [2:0]  ExFunc,
    output logic [2:0]  ExRd,
    output logic        ExRegWrite,
    output logic [15:0] ExRsVal,
    output logic [15:0] ExRtVal,
    output logic [15:0] ExImm,
    output logic [15:0] ExNextPC
);

    localparam logic [1:0] LP_FLUSH = FLUSH_SLOTS[1:0];

    ex_bundle_t  r_ex;
    logic [1:0]  r_flush;

    ex_bundle_t  w_dec;
    logic [3:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_rs_addr;
    logic [2:0]  w_rt_addr;
    logic        w_uses_rs;
    logic        w_uses_rt;
    logic        w_writes;
    logic        w_taken;
    logic [15:0] w_target;
    logic        w_pending;
    logic        w_hazard;
    logic        w_accept;
    logic        w_squash;
    logic        w_redirect;

    assign w_op = InstructIn[OP_HI:OP_LO];
    assign w_rd = InstructIn[RD_HI:RD_LO];

    // Branches name their source in the rd slot; stores name rt there.
    assign w_rs_addr = (w_op == OP_BEQZ || w_op == OP_BNEZ)
                     ? InstructIn[RD_HI:RD_LO]
                     : InstructIn[RS_HI:RS_LO];
    assign w_rt_addr = (w_op == OP_ST)
                     ? InstructIn[RD_HI:RD_LO]
                     : InstructIn[RT_HI:RT_LO];

    assign RsAddr = w_rs_addr;
    assign RtAddr = w_rt_addr;

    always_comb begin
        w_dec         = '0;
        w_uses_rs     = 1'b0;
        w_uses_rt     = 1'b0;
        w_writes      = 1'b0;
        w_taken       = 1'b0;
        w_target      = NextPCIn + sext9(InstructIn[8:0]);
        w_dec.valid   = 1'b1;
        w_dec.op      = w_op;
        w_dec.rs_val  = RsData;
        w_dec.rt_val  = RtData;
        w_dec.next_pc = NextPCIn;
        case (w_op)
            OP_R: begin
                w_uses_rs  = 1'b1;
                w_uses_rt  = 1'b1;
                w_writes   = 1'b1;
                w_dec.func = InstructIn[FUNC_HI:FUNC_LO];
            end
            OP_ADDI, OP_LD: begin
                w_uses_rs = 1'b1;
                w_writes  = 1'b1;
                w_dec.imm = sext6(InstructIn[5:0]);
            end
            OP_ST: begin
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
                w_dec.imm = sext6(InstructIn[5:0]);
            end
            OP_BEQZ: begin
                w_uses_rs = 1'b1;
                w_dec.imm = sext9(InstructIn[8:0]);
                w_taken   = (RsData == 16'd0);
            end
            OP_BNEZ: begin
                w_uses_rs = 1'b1;
                w_dec.imm = sext9(InstructIn[8:0]);
                w_taken   = (RsData != 16'd0);
            end
            OP_J: begin
                w_dec.imm = sext12(InstructIn[11:0]);
                w_taken   = 1'b1;
                w_target  = NextPCIn + sext12(InstructIn[11:0]);
            end
            OP_JR: begin
                w_uses_rs = 1'b1;
                w_taken   = 1'b1;
                w_target  = RsData;
            end
            default: ;
        endcase
        if (w_writes) begin
            w_dec.rd        = w_rd;
            w_dec.reg_write = (w_rd != 3'd0);
        end
    end

    assign w_pending = (r_flush != 2'd0);

    decode_hazard u_hazard (
        .i_en       (rst & ~w_pending),
        .i_ex_valid (r_ex.valid),
        .i_ex_op    (r_ex.op),
        .i_ex_rd    (r_ex.rd),
        .i_rs_addr  (w_rs_addr),
        .i_rt_addr  (w_rt_addr),
        .i_uses_rs  (w_uses_rs),
        .i_uses_rt  (w_uses_rt),
        .o_hazard   (w_hazard)
    );

    assign w_accept   = rst & ~DownStall & ~w_hazard;
    assign w_squash   = w_accept & w_pending;
    assign w_redirect = w_accept & ~w_pending & w_taken;

    assign Stall           = rst & (DownStall | w_hazard);
    assign NotBranchOrJump = ~w_redirect;
    assign TruePC          = w_redirect ? w_target : 16'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ex    <= '0;
            r_flush <= 2'd0;
        end else if (!DownStall) begin
            if (w_hazard || w_squash)
                r_ex <= '0;
            else
                r_ex <= w_dec;
            if (w_squash)
                r_flush <= r_flush - 2'd1;
            else if (w_redirect)
                r_flush <= LP_FLUSH;
        end
    end

    assign ExValid    = r_ex.valid;
    assign ExOp       = r_ex.op;
    assign ExFunc     = r_ex.func;
    assign ExRd       = r_ex.rd;
    assign ExRegWrite = r_ex.reg_write;
    assign ExRsVal    = r_ex.rs_val;
    assign ExRtVal    = r_ex.rt_val;
    assign ExImm      = r_ex.imm;
    assign ExNextPC   = r_ex.next_pc;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference model predicts each
// cycle's redirect/stall outputs and the Ex bundle one cycle later.
module tb_decode_stage;

    localparam int FS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] NextPCIn;
    logic [15:0] InstructIn;
    logic        DownStall;
    logic [2:0]  RsAddr;
    logic [2:0]  RtAddr;
    logic [15:0] RsData;
    logic [15:0] RtData;
    logic        Stall;
    logic [15:0] TruePC;
    logic        NotBranchOrJump;
    logic        ExValid;
    logic [3:0]  ExOp;
    logic [2:0]  ExFunc;
    logic [2:0]  ExRd;
    logic        ExRegWrite;
    logic [15:0] ExRsVal;
    logic [15:0] ExRtVal;
    logic [15:0] ExImm;
    logic [15:0] ExNextPC;

    typedef logic [75:0] exv_t;

    int   n_vec = 0;
    int   n_bad = 0;
    exv_t sb_q[$];
    exv_t m_ex;
    int   m_flush;

    logic        o_stall;
    logic        o_nbj;
    logic [15:0] o_tpc;

    always #5 clk = ~clk;

    decode_stage #(.FLUSH_SLOTS(FS)) dut (
        .clk             (clk),
        .rst             (rst),
        .NextPCIn        (NextPCIn),
        .InstructIn      (InstructIn),
        .DownStall       (DownStall),
        .RsAddr          (RsAddr),
        .RtAddr          (RtAddr),
        .RsData          (RsData),
        .RtData          (RtData),
        .Stall           (Stall),
        .TruePC          (TruePC),
        .NotBranchOrJump (NotBranchOrJump),
        .ExValid         (ExValid),
        .ExOp            (ExOp),
        .ExFunc          (ExFunc),
        .ExRd            (ExRd),
        .ExRegWrite      (ExRegWrite),
        .ExRsVal         (ExRsVal),
        .ExRtVal         (ExRtVal),
        .ExImm           (ExImm),
        .ExNextPC        (ExNextPC)
    );

    task automatic check_val(input string tag,
                             input logic [79:0] got,
                             input logic [79:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exv_t dut_ex();
        return {ExValid, ExOp, ExFunc, ExRd, ExRegWrite,
                ExRsVal, ExRtVal, ExImm, ExNextPC};
    endfunction

    task automatic step(input logic [15:0] ins,
                        input logic [15:0] npc,
                        input logic [15:0] rsd,
                        input logic [15:0] rtd,
                        input logic        down);
        logic [3:0]  op;
        logic [2:0]  a_rs, a_rt, rd;
        logic [15:0] tgt, imm;
        bit          rd_rs, rd_rt, hz, acc, sq, tk, wr;
        exv_t        nx;
        @(negedge clk);
        InstructIn = ins;
        NextPCIn   = npc;
        RsData     = rsd;
        RtData     = rtd;
        DownStall  = down;
        op    = ins[15:12];
        a_rs  = (op == 4'hC || op == 4'hD) ? ins[11:9] : ins[8:6];
        a_rt  = (op == 4'h9) ? ins[11:9] : ins[5:3];
        rd_rs = op inside {4'h0, 4'h1, 4'h8, 4'h9, 4'hC, 4'hD, 4'hF};
        rd_rt = op inside {4'h0, 4'h9};
        hz = !down && m_flush == 0 && m_ex[75]
             && m_ex[74:71] == 4'h8 && m_ex[67:65] != 3'd0
             && ((rd_rs && a_rs == m_ex[67:65])
                 || (rd_rt && a_rt == m_ex[67:65]));
        acc = !down && !hz;
        sq  = acc && m_flush > 0;
        tk  = acc && !sq && ((op == 4'hC && rsd == 0)
                             || (op == 4'hD && rsd != 0)
                             || op == 4'hE || op == 4'hF);
        if (op == 4'hF)
            tgt = rsd;
        else if (op == 4'hE)
            tgt = npc + {{4{ins[11]}}, ins[11:0]};
        else
            tgt = npc + {{7{ins[8]}}, ins[8:0]};
        #1;
        o_stall = Stall;
        o_nbj   = NotBranchOrJump;
        o_tpc   = TruePC;
        check_val("stall", Stall, down || hz);
        check_val("nbj", NotBranchOrJump, !tk);
        check_val("truepc", TruePC, tk ? tgt : 16'd0);
        check_val("rsaddr", RsAddr, a_rs);
        check_val("rtaddr", RtAddr, a_rt);
        wr  = op inside {4'h0, 4'h1, 4'h8};
        rd  = wr ? ins[11:9] : 3'd0;
        imm = 16'd0;
        if (op inside {4'h1, 4'h8, 4'h9})
            imm = {{10{ins[5]}}, ins[5:0]};
        else if (op inside {4'hC, 4'hD})
            imm = {{7{ins[8]}}, ins[8:0]};
        else if (op == 4'hE)
            imm = {{4{ins[11]}}, ins[11:0]};
        if (down)
            nx = m_ex;
        else if (hz || sq)
            nx = '0;
        else
            nx = {1'b1, op, (op == 4'h0) ? ins[2:0] : 3'd0, rd,
                  wr && rd != 3'd0, rsd, rtd, imm, npc};
        sb_q.push_back(nx);
        if (!down) begin
            if (sq)
                m_flush = m_flush - 1;
            else if (tk)
                m_flush = FS;
        end
        m_ex = nx;
        @(posedge clk);
        #1;
        check_val("ex_bundle", dut_ex(), sb_q.pop_front());
    endtask

    task automatic model_reset();
        m_ex    = '0;
        m_flush = 0;
        sb_q.delete();
    endtask

    initial begin
        logic [15:0] tbl[10];
        tbl = '{16'h1205, 16'h0448, 16'h8602, 16'h18C1, 16'hC204,
                16'hEFFE, 16'hD403, 16'hF140, 16'h5123, 16'h947F};
        rst = 1'b0;
        NextPCIn = '0;
        InstructIn = '0;
        DownStall = 1'b0;
        RsData = '0;
        RtData = '0;
        model_reset();
        #1;
        check_val("rst_stall", Stall, 1'b0);
        check_val("rst_nbj", NotBranchOrJump, 1'b1);
        check_val("rst_tpc", TruePC, 16'd0);
        check_val("rst_ex", dut_ex(), 76'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // ADDI r1,r0,5 then add r2,r1,r1
        step(16'h1205, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        check_val("addi_rd", ExRd, 3'd1);
        check_val("addi_we", ExRegWrite, 1'b1);
        step(16'h0448, 16'h0002, 16'h0005, 16'h0005, 1'b0);
        check_val("add_stall", o_stall, 1'b0);
        check_val("add_rd", ExRd, 3'd2);
        check_val("add_we", ExRegWrite, 1'b1);

        // write to r0 is dropped
        step(16'h0048, 16'h0003, 16'h0005, 16'h0005, 1'b0);
        check_val("r0_we", ExRegWrite, 1'b0);

        // load-use: one stall, one bubble, then ADDI
        step(16'h8602, 16'h0004, 16'h0000, 16'h0000, 1'b0);
        step(16'h18C1, 16'h0005, 16'h1234, 16'h0000, 1'b0);
        check_val("lu_stall", o_stall, 1'b1);
        check_val("lu_bubble", ExValid, 1'b0);
        step(16'h18C1, 16'h0005, 16'h1234, 16'h0000, 1'b0);
        check_val("lu_release", o_stall, 1'b0);
        check_val("lu_rsval", ExRsVal, 16'h1234);

        // BEQZ taken, then FS squashed slots
        step(16'hC204, 16'h0011, 16'h0000, 16'h0000, 1'b0);
        check_val("beqz_nbj", o_nbj, 1'b0);
        check_val("beqz_tpc", o_tpc, 16'h0015);
        step(16'h1205, 16'h0012, 16'h0000, 16'h0000, 1'b0);
        check_val("sq1_valid", ExValid, 1'b0);
        step(16'hEFFE, 16'h0013, 16'h0000, 16'h0000, 1'b0);
        check_val("sq2_nbj", o_nbj, 1'b1);
        check_val("sq2_valid", ExValid, 1'b0);
        step(16'h1205, 16'h0015, 16'h0000, 16'h0000, 1'b0);
        check_val("post_sq", ExValid, 1'b1);

        // J wraps; BNEZ with zero not taken; JR
        step(16'hEFFE, 16'h0001, 16'h0000, 16'h0000, 1'b0);
        check_val("j_wrap", o_tpc, 16'hFFFF);
        step(16'h5123, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        step(16'h5123, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step(16'hD403, 16'h0020, 16'h0000, 16'h0000, 1'b0);
        check_val("bnez_nt", o_nbj, 1'b1);
        step(16'hF140, 16'h0021, 16'hBEEF, 16'h0000, 1'b0);
        check_val("jr_tpc", o_tpc, 16'hBEEF);
        step(16'h947F, 16'h0022, 16'h0001, 16'h0002, 1'b0);
        step(16'h947F, 16'h0023, 16'h0001, 16'h0002, 1'b0);

        // DownStall during pending flush
        step(16'hEFFE, 16'h0100, 16'h0000, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(16'hEFFE, 16'h0101, 16'h0000, 16'h0000, 1'b1);
            check_val("ds_nbj", o_nbj, 1'b1);
            check_val("ds_hold_op", ExOp, 4'hE);
        end
        step(16'hEFFE, 16'h0101, 16'h0000, 16'h0000, 1'b0);
        check_val("ds_sq_nbj", o_nbj, 1'b1);
        step(16'h1205, 16'h0102, 16'h0000, 16'h0000, 1'b0);
        step(16'h1205, 16'h00FF, 16'h0000, 16'h0000, 1'b0);
        check_val("ds_resume", ExValid, 1'b1);

        // reset pulse during a load-use stall
        step(16'h8602, 16'h0200, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        InstructIn = 16'h18C1;
        #1;
        check_val("pre_rst_stall", Stall, 1'b1);
        rst = 1'b0;
        #1;
        check_val("mid_rst_stall", Stall, 1'b0);
        check_val("mid_rst_nbj", NotBranchOrJump, 1'b1);
        check_val("mid_rst_tpc", TruePC, 16'd0);
        check_val("mid_rst_ex", dut_ex(), 76'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        step(16'h18C1, 16'h0201, 16'h0007, 16'h0000, 1'b0);
        check_val("post_rst_stall", o_stall, 1'b0);
        check_val("post_rst_rd", ExRd, 3'd4);

        // random mix
        for (int i = 0; i < 80; i++) begin
            step(tbl[$urandom_range(0, 9)],
                 16'($urandom),
                 ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom),
                 16'($urandom),
                 $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
